// File: rtl/fifo_wr_feeder.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_feeder
// Brief   : Write-side stream front end for the async FIFO: 2-entry skid
//           buffer, lag-compensated overflow guard, registered fill level.
// Rev     : 1.0  initial release
// ============================================================================
module fifo_wr_feeder #(
    parameter int D_WIDTH   = 8,
    parameter int P_SIZE    = 5,
    parameter int AF_THRESH = 12
) (
    input  logic               w_clk,
    input  logic               w_rstn,
    input  logic               s_valid,
    input  logic [D_WIDTH-1:0] s_data,
    output logic               s_ready,
    input  logic               full,
    input  logic [P_SIZE-1:0]  gray_w_ptr,
    input  logic [P_SIZE-1:0]  sync_rd_ptr,
    output logic               w_inc,
    output logic [D_WIDTH-1:0] w_data,
    output logic [P_SIZE-1:0]  w_level,
    output logic               almost_full
);

    localparam int                DEPTH   = 2 ** (P_SIZE - 1);
    localparam logic [P_SIZE-1:0] C_DEPTH = P_SIZE'(DEPTH);
    localparam logic [P_SIZE-1:0] C_AF    = P_SIZE'(AF_THRESH);

    function automatic logic [P_SIZE-1:0] gray2bin(input logic [P_SIZE-1:0] g);
        logic [P_SIZE-1:0] b;
        b[P_SIZE-1] = g[P_SIZE-1];
        for (int i = P_SIZE - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic               r_out_valid;
    logic [D_WIDTH-1:0] r_out_data;
    logic               r_skid_valid;
    logic [D_WIDTH-1:0] r_skid_data;
    logic               r_s_ready;
    logic               r_inc_q;
    logic [P_SIZE-1:0]  r_level;
    logic               r_af;

    logic [P_SIZE-1:0]  w_raw_level;
    logic [P_SIZE-1:0]  w_eff_level;
    logic               w_can_write;
    logic               w_write;
    logic               w_accept;
    logic               w_out_valid_nxt;
    logic [D_WIDTH-1:0] w_out_data_nxt;
    logic               w_skid_valid_nxt;
    logic [D_WIDTH-1:0] w_skid_data_nxt;

    // gray_w_ptr trails the real write count by one cycle; r_inc_q covers
    // the write that is committed but not yet visible.
    assign w_raw_level = gray2bin(gray_w_ptr) - gray2bin(sync_rd_ptr);
    assign w_eff_level = w_raw_level + {{(P_SIZE-1){1'b0}}, r_inc_q};
    assign w_can_write = !full && (w_eff_level < C_DEPTH);
    assign w_write     = r_out_valid && w_can_write;
    assign w_accept    = s_valid && r_s_ready;

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (!r_out_valid || w_write) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = r_skid_data;
                w_skid_valid_nxt = w_accept;
                if (w_accept) begin
                    w_skid_data_nxt = s_data;
                end
            end else if (w_accept) begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = s_data;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = s_data;
        end
    end

    // r_s_ready resets low and first rises on the edge after reset release,
    // so it doubles as the reset-done marker.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_s_ready    <= 1'b0;
            r_inc_q      <= 1'b0;
            r_level      <= '0;
            r_af         <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_s_ready    <= !w_skid_valid_nxt;
            r_inc_q      <= w_write;
            r_level      <= w_eff_level;
            r_af         <= (w_eff_level >= C_AF);
        end
    end

    assign s_ready     = r_s_ready;
    assign w_inc       = w_write;
    assign w_data      = r_out_data;
    assign w_level     = r_level;
    assign almost_full = r_af;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_feeder
// Brief   : Directed self-checking bench for fifo_wr_feeder with a write
//           pointer stage / reader model and an in-order data scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fifo_wr_feeder;

    localparam logic [7:0] BASE = 8'h40;

    logic       w_clk = 1'b0;
    logic       w_rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       full_s;
    logic [4:0] gray_w_s;
    logic [4:0] sync_rd_s;
    logic       w_inc;
    logic [7:0] w_data;
    logic [4:0] w_level;
    logic       almost_full;

    fifo_wr_feeder #(.D_WIDTH(8), .P_SIZE(5), .AF_THRESH(12)) dut (
        .w_clk      (w_clk),
        .w_rstn     (w_rstn),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .full       (full_s),
        .gray_w_ptr (gray_w_s),
        .sync_rd_ptr(sync_rd_s),
        .w_inc      (w_inc),
        .w_data     (w_data),
        .w_level    (w_level),
        .almost_full(almost_full)
    );

    always #5 w_clk = ~w_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Write pointer stage + reader model: binary pointer, Gray copy one cycle behind.
    logic       use_model = 1'b0;
    logic       rd_en = 1'b0;
    logic       force_full = 1'b0;
    logic [4:0] tbl_gw = 5'd0;
    logic [4:0] tbl_gr = 5'd0;
    logic [4:0] m_wbin, m_gray, m_rbin, m_rgray;
    logic       m_full;

    always @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            m_wbin <= 5'd0;
            m_gray <= 5'd0;
            m_rbin <= 5'd0;
        end else begin
            m_wbin <= m_wbin + {4'd0, w_inc};
            m_gray <= m_wbin ^ (m_wbin >> 1);
            if (rd_en && (m_rbin != m_wbin)) m_rbin <= m_rbin + 5'd1;
        end
    end

    assign m_rgray   = m_rbin ^ (m_rbin >> 1);
    assign m_full    = (m_gray == {~m_rgray[4:3], m_rgray[2:0]});
    assign gray_w_s  = use_model ? m_gray : tbl_gw;
    assign sync_rd_s = use_model ? m_rgray : tbl_gr;
    assign full_s    = (use_model && m_full) || force_full;

    // Monitor: scoreboard, level tracking, event cycle stamps.
    logic [7:0] sb[$];
    int         inc_cnt, cyc, first_acc, first_inc, last_inc, lvl12, af_cyc, max_lvl;
    logic [4:0] prev_occ;
    logic [4:0] occ;
    logic [7:0] last_wdata;

    always @(negedge w_clk) begin
        if (!w_rstn) begin
            sb.delete();
            inc_cnt = 0; cyc = 0; first_acc = -1; first_inc = -1; last_inc = -1;
            lvl12 = -1; af_cyc = -1; max_lvl = 0; prev_occ = 5'd0; last_wdata = 8'h00;
        end else begin
            occ = m_wbin - m_rbin;
            if (use_model) begin
                chk("w_level_vs_model", w_level, prev_occ);
                prev_occ = occ;
            end
            if (int'(w_level) > max_lvl) max_lvl = int'(w_level);
            if (lvl12 < 0 && w_level >= 5'd12) lvl12 = cyc;
            if (af_cyc < 0 && almost_full) af_cyc = cyc;
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                if (first_acc < 0) first_acc = cyc;
            end
            if (w_inc) begin
                inc_cnt++;
                if (first_inc < 0) first_inc = cyc;
                last_inc = cyc;
                last_wdata = w_data;
                if (sb.size() == 0) chk("write_without_pending_word", 32'd1, 32'd0);
                else chk("w_data_order", w_data, sb.pop_front());
                if (use_model) chk("no_overflow", 32'(occ < 5'd16), 32'd1);
            end
            cyc++;
        end
    end

    // Upstream driver
    logic       acc_pend = 1'b0;
    logic       src_en = 1'b0;
    logic       stall_req = 1'b0;
    int         n_acc = 0;
    int         acc_lim = 0;
    logic [7:0] next_data = BASE;

    task automatic step();
        @(posedge w_clk);
        #1;
        if (acc_pend) begin
            next_data = next_data + 8'd1;
            n_acc++;
        end
        s_valid    = src_en && (n_acc < acc_lim);
        s_data     = next_data;
        force_full = stall_req;
        @(negedge w_clk);
        acc_pend = s_valid && s_ready;
    endtask

    task automatic do_reset();
        @(posedge w_clk);
        #1;
        w_rstn = 1'b0; s_valid = 1'b0; acc_pend = 1'b0; n_acc = 0;
        next_data = BASE; stall_req = 1'b0; force_full = 1'b0;
        repeat (2) @(posedge w_clk);
        #1 w_rstn = 1'b1;
    endtask

    typedef struct {
        logic [4:0] gw;
        logic [4:0] gr;
        logic [4:0] exp_level;
        logic       exp_af;
    } lvl_vec_t;

    lvl_vec_t vecs[7];

    initial begin
        // Gray inputs with hand-computed modulo-32 differences.
        vecs[0] = '{5'b00111, 5'b00000, 5'd5,  1'b0};  // 5 - 0
        vecs[1] = '{5'b01010, 5'b00000, 5'd12, 1'b1};  // 12 - 0
        vecs[2] = '{5'b11000, 5'b00000, 5'd16, 1'b1};  // 16 - 0
        vecs[3] = '{5'b00010, 5'b10001, 5'd5,  1'b0};  // 3 - 30
        vecs[4] = '{5'b00000, 5'b11110, 5'd12, 1'b1};  // 0 - 20
        vecs[5] = '{5'b10000, 5'b11110, 5'd11, 1'b0};  // 31 - 20
        vecs[6] = '{5'b01101, 5'b01101, 5'd0,  1'b0};  // 9 - 9

        // Reset state
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_w_inc", w_inc, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_w_level", w_level, 0);
        chk("rst_almost_full", almost_full, 0);
        @(posedge w_clk);
        #1 w_rstn = 1'b1;
        @(negedge w_clk);
        chk("ready_low_before_first_edge", s_ready, 0);
        @(negedge w_clk);
        chk("ready_after_first_edge", s_ready, 1);

        // Level / almost_full table with pipeline idle
        for (int i = 0; i < 7; i++) begin
            @(posedge w_clk);
            #1;
            tbl_gw = vecs[i].gw;
            tbl_gr = vecs[i].gr;
            @(posedge w_clk);
            @(negedge w_clk);
            chk($sformatf("tbl%0d_w_level", i), w_level, vecs[i].exp_level);
            chk($sformatf("tbl%0d_almost_full", i), almost_full, vecs[i].exp_af);
            chk($sformatf("tbl%0d_w_inc", i), w_inc, 0);
        end

        // Stream 8 words, reader running
        use_model = 1'b1;
        do_reset();
        rd_en = 1'b1; src_en = 1'b1; acc_lim = 8;
        repeat (14) step();
        chk("stream8_inc_count", inc_cnt, 8);
        chk("stream8_first_latency", first_inc - first_acc, 1);
        chk("stream8_consecutive", last_inc - first_inc, 7);
        chk("stream8_drained", sb.size(), 0);

        // Reader frozen
        do_reset();
        rd_en = 1'b0; acc_lim = 1000;
        repeat (30) step();
        chk("frozen_inc_count", inc_cnt, 16);
        chk("frozen_w_level", w_level, 16);
        chk("frozen_almost_full", almost_full, 1);
        chk("frozen_s_ready", s_ready, 0);
        chk("frozen_words_held", sb.size(), 2);
        chk("af_seen", 32'(lvl12 >= 0), 1);
        chk("af_rise_cycle", af_cyc, lvl12);

        // Release reader by one entry
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        repeat (6) step();
        chk("release1_inc_count", inc_cnt, 17);
        chk("release1_word", last_wdata, 32'h50);
        chk("release1_words_held", sb.size(), 2);

        // Pointer wrap with random reader
        do_reset();
        acc_lim = 100;
        for (int i = 0; i < 3000 && inc_cnt < 100; i++) begin
            rd_en = 1'($urandom_range(0, 1));
            step();
        end
        chk("wrap_inc_count", inc_cnt, 100);
        chk("wrap_max_level", 32'(max_lvl <= 16), 1);
        chk("wrap_drained", sb.size(), 0);

        // One-cycle backpressure mid-burst
        do_reset();
        rd_en = 1'b1; acc_lim = 20;
        repeat (5) step();
        stall_req = 1'b1;
        step();
        chk("stall_no_write", w_inc, 0);
        chk("stall_ready_still_high", s_ready, 1);
        stall_req = 1'b0;
        step();
        chk("skid_ready_low", s_ready, 0);
        chk("resume_write", w_inc, 1);
        step();
        chk("skid_drained_ready", s_ready, 1);
        chk("resume_write2", w_inc, 1);
        repeat (25) step();
        chk("stall_inc_count", inc_cnt, 20);
        chk("stall_gap_free_span", last_inc - first_inc, 20);
        chk("stall_drained", sb.size(), 0);

        // Reset with two words buffered
        do_reset();
        rd_en = 1'b0; acc_lim = 1000; stall_req = 1'b1;
        repeat (4) step();
        chk("pre_reset_ready_low", s_ready, 0);
        chk("pre_reset_held", sb.size(), 2);
        #2 w_rstn = 1'b0;
        #1;
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_w_inc", w_inc, 0);
        chk("midrst_w_data", w_data, 0);
        chk("midrst_w_level", w_level, 0);
        chk("midrst_almost_full", almost_full, 0);
        stall_req = 1'b0; force_full = 1'b0; acc_lim = 0;
        @(posedge w_clk);
        #1;
        w_rstn = 1'b1; acc_pend = 1'b0; n_acc = 0;
        step();
        chk("post_rst_ready", s_ready, 1);
        chk("post_rst_no_inc", w_inc, 0);
        repeat (5) step();
        chk("no_stale_write", inc_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_feeder.md
# fifo_wr_feeder

Write-domain stream front end for the async FIFO. It sits directly upstream of the write pointer/full-flag stage. It accepts data on a valid/ready interface, buffers it in a 2-entry skid buffer, and issues `w_inc`/`w_data` to the write stage and FIFO memory. It guarantees no write is ever issued that would overflow the FIFO, even though the write-pointer Gray code (and therefore `full`) lags the binary pointer by one cycle. It also publishes a registered fill level and an almost-full flag for upstream flow control.

## Interface
- `D_WIDTH`, default 8: data word width.
- `P_SIZE`, default 5: pointer width. FIFO depth `DEPTH = 2^(P_SIZE-1)`.
- `AF_THRESH`, default 12: `almost_full` asserts when `w_level >= AF_THRESH`. Legal range 1..DEPTH.
- `w_clk`  in  1  write-domain clock.
- `w_rstn`  in  1  write-domain reset, asynchronous, active-low.
- `s_valid`  in  1  upstream data valid.
- `s_data`  in  D_WIDTH  upstream data.
- `s_ready`  out  1  upstream may transfer this cycle (registered).
- `full`  in  1  full flag from write pointer stage.
- `gray_w_ptr`  in  P_SIZE  registered Gray write pointer from write pointer stage.
- `sync_rd_ptr`  in  P_SIZE  Gray read pointer synchronized into w_clk.
- `w_inc`  out  1  write strobe to write pointer stage and memory write enable.
- `w_data`  out  D_WIDTH  write data to memory (registered).
- `w_level`  out  P_SIZE  registered effective fill level, 0..DEPTH.
- `almost_full`  out  1  registered, `w_level >= AF_THRESH`.

## Operation
- Gray-to-binary conversion of both pointers: `b[P_SIZE-1] = g[P_SIZE-1]`; for each lower bit, `b[i] = b[i+1] ^ g[i]`.
- `raw_level = bin(gray_w_ptr) - bin(sync_rd_ptr)`, computed modulo 2^P_SIZE, P_SIZE bits wide. This is correct across pointer wrap.
- `inc_q` is a register holding the previous cycle's `w_inc`. It accounts for the one write not yet visible in `gray_w_ptr`.
- `eff_level = raw_level + inc_q`. This never exceeds DEPTH in legal operation.
- `can_write = !full && (eff_level < DEPTH)`.
- Internal state:
  - Output register: `out_valid`, `out_data`. `w_data = out_data`.
  - Skid register: `skid_valid`, `skid_data`.
- `w_inc = out_valid && can_write`. This is the only combinational output.
- `accept = s_valid && s_ready`.
- Output register update on each edge:
  - If `!out_valid || w_inc`, load from skid if `skid_valid` and clear the skid. Otherwise load from `s_data` if `accept`. Otherwise set `out_valid = 0`.
  - Else (stalled): if `accept`, capture `s_data` into the skid and set `skid_valid = 1`.
- `rst_done` is a register that goes to 1 on the first edge after reset release. `s_ready` is registered as `rst_done && !next_skid_valid`.
- Ordering is strict FIFO: the skid entry always drains before new input.
- `w_level` registers `eff_level` every cycle. `almost_full` registers `eff_level >= AF_THRESH`.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - `s_ready`, `w_inc`, `w_data`, `w_level`, `almost_full`, `out_valid`, `skid_valid`, `inc_q` are all 0.
  - `s_ready` rises on the first `w_clk` edge after `w_rstn` deasserts.
- Latency: a word accepted at edge N drives `w_inc` in cycle N+1 at the earliest.
- Throughput: 1 word/cycle sustained while `can_write` stays high.
- Stall: while `can_write = 0`, `w_inc` is 0 and `out_data` holds. One more word may enter the skid, then `s_ready` drops.
- Full boundary: at most DEPTH writes are issued before `sync_rd_ptr` advances. No write occurs on the cycle after the DEPTH-th write, even though `full` is still low then.
- Simultaneous drain and accept: the output loads from the skid and the new word goes to the skid in the same edge. `skid_valid` stays 1 and `s_ready` stays 0.
- `w_level` and `almost_full` lag `eff_level` by one cycle.
- Reset mid-operation discards buffered words. No `w_inc` is issued during reset or in the first cycle after release.

## Test plan
- Stream 8 words, reader advancing, no full: `w_inc` fires in 8 consecutive cycles starting 1 cycle after the first accept, and data arrives in order.
- Reader frozen (`sync_rd_ptr = 0`), upstream streams continuously:
  - Exactly 16 `w_inc` pulses (`P_SIZE = 5`), then no more.
  - `w_level` reaches 16. `almost_full` rises on the cycle `w_level` first reads 12.
  - `s_ready` falls with 2 words held.
  - The write stage never overwrites.
- Release the reader by one entry: exactly one further `w_inc` fires, carrying the oldest held word.
- Pointer wrap: run 100 words with a random reader rate. `w_level` stays within 0..16 and matches a scoreboard count at every wrap of the 5-bit pointers.
- Backpressure toggle: stall `can_write` for one cycle mid-burst. The skid captures exactly one word, and the output sequence is gap-free and in order after release.
- Assert `w_rstn` with 2 words buffered: all outputs are 0 immediately. After release, `s_ready` rises 1 cycle later and no stale word is written.
